mandel_cfg_serializer: RTL and testbench
========================================

Name: mandel_cfg_serializer

Overview:
On-chip transmitter for the three-wire configuration link (sen, sclk, sdata) that loads the Mandelbrot engine's 33-bit configuration shift register. It takes a parallel configuration word and emits a frame: LSB first, one bit per sclk rising edge, with sen framing the transfer. The sclk timing tolerates the receiver's 3-flop input synchronisers. It lets a zoom/pan sequencer, or a loopback test, drive the same link the RP2040 drives.

Parameters:
WIDTH, 33, bits per frame; must equal the receiver's configuration register width.
HALF_PERIOD, 4, sclk half-period in clk cycles; legal minimum 2, maximum 255.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle request; sampled only in IDLE
cfg_word  input  WIDTH  word to send; latched on the accepted start
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when a frame completes
sen  output  1  frame enable, active high
sclk  output  1  serial clock; the receiver samples on the rising edge
sdata  output  1  serial data, LSB of cfg_word first

Behaviour:
- All outputs are registered. Reset (rst_n=0 at a clk edge) forces IDLE, with sen=sclk=sdata=busy=done=0. The shift register and counters clear to 0.
- Reset mid-frame aborts the frame. Outputs are 0 from the following cycle. No done pulse is issued. The receiver holds a partial shift, and the next full frame overwrites all WIDTH bits.
- Internal state: phase counter 0..HALF_PERIOD-1, bit counter 0..WIDTH, shift register WIDTH bits.
- IDLE: sen=0, sclk=0, sdata=0, busy=0.
  - start=1 latches cfg_word, sets busy=1, sen=1, sdata=cfg_word[0], sclk=0, and moves to LEAD.
- LEAD: sclk=0 for HALF_PERIOD cycles, so sen is settled before the first rising edge. Then move to HIGH.
- HIGH: sclk=1 for HALF_PERIOD cycles; sdata is stable. On exit, increment the bit counter.
  - If the count reaches WIDTH, move to TAIL.
  - Otherwise move to LOW: shift right and drive sdata with the next bit in the same cycle sclk falls.
- LOW: sclk=0 for HALF_PERIOD cycles, then move to HIGH.
- TAIL: sclk=0 and sen=1 held for HALF_PERIOD cycles. Then sen=0, busy=0, done=1 for exactly one cycle, and return to IDLE.
- Frame length:
  - sen is high for (2*WIDTH+1)*HALF_PERIOD cycles: 268 at the defaults.
  - Exactly WIDTH sclk rising edges per frame.
  - done is asserted on the first cycle with sen=0.
- sdata changes only while sclk=0, or on the cycle sclk goes 1→0. It never changes on a 0→1 transition.
- start while busy=1 is ignored and not queued.
- start coincident with done: done is registered, so the FSM is already in IDLE and the start is accepted. The new frame's sen rises the next cycle. sen is low for at least 1 cycle between frames.
- cfg_word changes after acceptance have no effect on the frame in flight.

Test Plan:
- Loopback at defaults: attach a receiver model (3-flop sync on sen/sclk/sdata; on sync'd sclk rising edge with sen high, shift in at the MSB, shift right). Send cfg_word=33'h1_2345_6789 → receiver register = 33'h1_2345_6789; done pulses once; busy high for 268 cycles.
- Edge count/timing: HALF_PERIOD=2, cfg_word=33'h0_0000_0001 → 33 sclk rising edges; sen high for 134 cycles; every sclk high and low phase is ≥2 cycles; sdata=1 only before the first rising edge.
- Ignored start: pulse start at cycle 50 of a frame carrying 33'h0_FFFF_0000 with cfg_word=33'h1_0000_FFFF → only one frame; receiver = 33'h0_FFFF_0000; one done pulse.
- Back-to-back: send 33'h0_AAAA_AAAA, then assert start on the done cycle with 33'h1_5555_5555 → the second frame starts the next cycle; sen low for ≥1 cycle between frames; receiver ends at 33'h1_5555_5555.
- Reset mid-frame: assert rst_n=0 at bit 10 for 1 cycle → next cycle sen=sclk=sdata=busy=done=0 with no done pulse; then send 33'h0_0F0F_0F0F → receiver = 33'h0_0F0F_0F0F.

Source files
------------

// File: rtl/mandel_cfg_serializer.sv
// mandel_cfg_serializer: serialises a configuration word onto the sen/sclk/sdata link, LSB first.
module mandel_cfg_serializer #(
  parameter int WIDTH = 33,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_word,
  output logic             busy,
  output logic             done,
  output logic             sen,
  output logic             sclk,
  output logic             sdata
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [7:0] PH_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TAIL} state_t;
  state_t state;
  logic [7:0] phase;
  logic [BW-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic ph_end;
  assign ph_end = phase == PH_LAST;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sen <= 1'b0;
      sclk <= 1'b0;
      sdata <= 1'b0;
    end else begin
      done <= 1'b0;
      phase <= (state == IDLE || ph_end) ? '0 : phase + 8'd1;
      case (state)
        IDLE: if (start) begin
          shreg <= cfg_word;
          sdata <= cfg_word[0];
          sen <= 1'b1;
          busy <= 1'b1;
          bit_cnt <= '0;
          state <= LEAD;
        end
        LEAD, LOW: if (ph_end) begin
          sclk <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (ph_end) begin
          sclk <= 1'b0;
          bit_cnt <= bit_cnt + BW'(1);
          // next bit goes out on the same edge sclk falls, never on a rise
          if (bit_cnt == BIT_LAST) state <= TAIL;
          else begin
            shreg <= shreg >> 1;
            sdata <= shreg[1];
            state <= LOW;
          end
        end
        TAIL: if (ph_end) begin
          sen <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          sdata <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandel_cfg_serializer.sv
// tb_mandel_cfg_serializer: loopback bench with a synchronising receiver model and a frame scoreboard.
module tb_mandel_cfg_serializer;
  localparam int W = 33;
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  logic [W-1:0] cfg_word = '0, cfg2 = '0;
  logic busy, done, sen, sclk, sdata;
  logic busy2, done2, sen2, sclk2, sdata2;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mandel_cfg_serializer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_word(cfg_word),
    .busy(busy), .done(done), .sen(sen), .sclk(sclk), .sdata(sdata)
  );

  mandel_cfg_serializer #(.WIDTH(W), .HALF_PERIOD(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cfg_word(cfg2),
    .busy(busy2), .done(done2), .sen(sen2), .sclk(sclk2), .sdata(sdata2)
  );

  // receiver: 3-flop synchronisers, shift in at MSB on synchronised sclk rise while sen
  logic [2:0] sen_s = '0, sd_s = '0;
  logic [3:0] sclk_s = '0;
  logic [W-1:0] rx = '0;
  always @(posedge clk) begin
    sen_s <= {sen_s[1:0], sen};
    sd_s <= {sd_s[1:0], sdata};
    sclk_s <= {sclk_s[2:0], sclk};
    if (sen_s[2] && sclk_s[2] && !sclk_s[3]) rx <= {sd_s[2], rx[W-1:1]};
  end

  int sen_cyc = 0, busy_cyc = 0, done_cnt = 0, rises = 0, bad_sd = 0;
  logic p_sclk = 0, p_sd = 0;
  always @(negedge clk) begin
    if (sen === 1'b1) sen_cyc <= sen_cyc + 1;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (sclk === 1'b1 && !p_sclk) begin
      rises <= rises + 1;
      if (sdata !== p_sd) bad_sd <= bad_sd + 1;
    end
    p_sclk <= sclk;
    p_sd <= sdata;
  end

  int sen2_cyc = 0, rises2 = 0, falls2 = 0, sd_bad2 = 0, done2_cnt = 0, run = 0;
  int min_hi = 1000, min_lo = 1000;
  logic p_sclk2 = 0, p_sen2 = 0, first_sd = 0;
  always @(negedge clk) begin
    p_sclk2 <= sclk2;
    p_sen2 <= sen2;
    if (sen2 === 1'b1) sen2_cyc <= sen2_cyc + 1;
    if (done2 === 1'b1) done2_cnt <= done2_cnt + 1;
    if (sclk2 === 1'b1 && !p_sclk2) begin
      rises2 <= rises2 + 1;
      if (rises2 == 0) first_sd <= sdata2;
    end
    if (sclk2 === 1'b0 && p_sclk2) falls2 <= falls2 + 1;
    if (sdata2 === 1'b1 && falls2 > 0) sd_bad2 <= sd_bad2 + 1;
    if (sen2 === 1'b1 && !p_sen2) run <= 1;
    else if (sen2 === 1'b1 && p_sen2) begin
      if (sclk2 === p_sclk2) run <= run + 1;
      else begin
        run <= 1;
        if (p_sclk2) min_hi <= (run < min_hi) ? run : min_hi;
        else min_lo <= (run < min_lo) ? run : min_lo;
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input bit push);
    @(posedge clk); #1;
    cfg_word = w;
    start = 1;
    if (push) exp_q.push_back(w);
    @(posedge clk); #1;
    start = 0;
    cfg_word = ~w;
  endtask

  task automatic wait_done(input string tag);
    logic [W-1:0] e;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout got %b exp 1", tag, done);
    end else begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard_empty got done exp none", tag);
      end else begin
        e = exp_q.pop_front();
        if (rx !== e) begin
          errors++;
          $display("FAIL %s rx got %h exp %h", tag, rx, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sen, sclk, sdata} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs got %b exp 00000", {busy, done, sen, sclk, sdata});
    end
    checks++;
    if ({busy2, done2, sen2, sclk2, sdata2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs2 got %b exp 00000", {busy2, done2, sen2, sclk2, sdata2});
    end
    rst_n = 1;
  endtask

  task automatic test_loopback();
    int b_busy, b_sen, b_done, b_r, b_bad;
    b_busy = busy_cyc; b_sen = sen_cyc; b_done = done_cnt; b_r = rises; b_bad = bad_sd;
    send(33'h1_2345_6789, 1);
    wait_done("loopback");
    checks++;
    if (sen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loopback_done_cycle got sen=%b busy=%b exp 0 0", sen, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy_cyc - b_busy != 268) begin
      errors++;
      $display("FAIL loopback_busy_len got %0d exp 268", busy_cyc - b_busy);
    end
    checks++;
    if (sen_cyc - b_sen != 268) begin
      errors++;
      $display("FAIL loopback_sen_len got %0d exp 268", sen_cyc - b_sen);
    end
    checks++;
    if (done_cnt - b_done != 1) begin
      errors++;
      $display("FAIL loopback_done_cnt got %0d exp 1", done_cnt - b_done);
    end
    checks++;
    if (rises - b_r != W) begin
      errors++;
      $display("FAIL loopback_rises got %0d exp %0d", rises - b_r, W);
    end
    checks++;
    if (bad_sd != b_bad) begin
      errors++;
      $display("FAIL loopback_sdata_on_rise got %0d exp 0", bad_sd - b_bad);
    end
  endtask

  task automatic test_edge_timing();
    int n;
    @(posedge clk); #1;
    cfg2 = 33'h0_0000_0001;
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    cfg2 = '1;
    n = 0;
    while (done2 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done2 !== 1'b1) begin
      errors++;
      $display("FAIL edge_done_timeout got %b exp 1", done2);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sen2_cyc != 134) begin errors++; $display("FAIL edge_sen_len got %0d exp 134", sen2_cyc); end
    checks++;
    if (rises2 != W) begin errors++; $display("FAIL edge_rises got %0d exp %0d", rises2, W); end
    checks++;
    if (min_hi != 2) begin errors++; $display("FAIL edge_min_high got %0d exp 2", min_hi); end
    checks++;
    if (min_lo != 2) begin errors++; $display("FAIL edge_min_low got %0d exp 2", min_lo); end
    checks++;
    if (first_sd !== 1'b1) begin errors++; $display("FAIL edge_first_bit got %b exp 1", first_sd); end
    checks++;
    if (sd_bad2 != 0) begin errors++; $display("FAIL edge_sdata_late got %0d exp 0", sd_bad2); end
    checks++;
    if (done2_cnt != 1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL edge_done_cnt got %0d busy %b exp 1 0", done2_cnt, busy2);
    end
  endtask

  task automatic test_ignored_start();
    int b_done;
    b_done = done_cnt;
    send(33'h0_FFFF_0000, 1);
    repeat (48) @(posedge clk);
    #1;
    cfg_word = 33'h1_0000_FFFF;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignored_busy got %b exp 1", busy); end
    wait_done("ignored");
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt - b_done != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_frames got %0d busy %b exp 1 0", done_cnt - b_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    send(33'h0_AAAA_AAAA, 1);
    wait_done("b2b_first");
    checks++;
    if (sen !== 1'b0) begin errors++; $display("FAIL b2b_gap got sen=%b exp 0", sen); end
    cfg_word = 33'h1_5555_5555;
    start = 1;
    exp_q.push_back(33'h1_5555_5555);
    @(posedge clk); #1;
    start = 0;
    cfg_word = '0;
    checks++;
    if (sen !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got sen=%b busy=%b exp 1 1", sen, busy);
    end
    wait_done("b2b_second");
  endtask

  task automatic test_reset_mid();
    int b_r, b_done, n;
    b_r = rises;
    send(33'h1_FFFF_FFFF, 0);
    n = 0;
    while (rises - b_r < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rises - b_r < 10) begin errors++; $display("FAIL mid_reach_bit10 got %0d exp 10", rises - b_r); end
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if ({busy, done, sen, sclk, sdata} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_outs got %b exp 00000", {busy, done, sen, sclk, sdata});
    end
    b_done = done_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != b_done || sen !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done got %0d sen %b exp 0 0", done_cnt - b_done, sen);
    end
    send(33'h0_0F0F_0F0F, 1);
    wait_done("mid_refill");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_edge_timing();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
